// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and PC alignment.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t CTR_RST     = WNT;
  localparam int   ALIGN_SHIFT = 2;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter; one-cycle update when en is high, no backpressure.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic up,
  output ctr_t cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= CTR_RST;
    end else if (en) begin
      if (up && cnt != ST) begin
        cnt <= ctr_t'(cnt + 2'd1);
      end else if (!up && cnt != SNT) begin
        cnt <= ctr_t'(cnt - 2'd1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// BTB + PHT branch predictor (bimodal or gshare): zero-latency lookup, resolve updates on next edge.
// No backpressure: one lookup and one resolve accepted every cycle.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BTB_IDX  = 6,
  parameter int PHT_IDX  = 8,
  parameter int GHR_BITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               f_valid,
  input  logic [XLEN-1:0]    f_pc,
  output logic               p_taken,
  output logic [XLEN-1:0]    p_target,
  output logic [PHT_IDX-1:0] p_index,
  input  logic               r_valid,
  input  logic               r_is_branch,
  input  logic [XLEN-1:0]    r_pc,
  input  logic [PHT_IDX-1:0] r_index,
  input  logic               r_taken,
  input  logic [XLEN-1:0]    r_target,
  input  logic               r_pred_taken,
  input  logic [XLEN-1:0]    r_pred_target,
  output logic               r_mispredict,
  output logic [31:0]        branch_count,
  output logic [31:0]        mispred_count
);

  localparam int BTB_N = 1 << BTB_IDX;
  localparam int PHT_N = 1 << PHT_IDX;
  localparam int TAG_W = XLEN - BTB_IDX - ALIGN_SHIFT;

  logic [BTB_N-1:0] btb_vld;
  logic [TAG_W-1:0] btb_tag [BTB_N];
  logic [XLEN-1:0]  btb_tgt [BTB_N];
  ctr_t             pht     [PHT_N];

  logic [BTB_IDX-1:0] f_bidx, r_bidx;
  logic [TAG_W-1:0]   f_tag, r_tag;
  logic [PHT_IDX-1:0] ghr_ext;
  logic               btb_hit;
  logic               upd;
  logic [3:0]         unused_pc_bits;

  assign f_bidx         = f_pc[BTB_IDX+ALIGN_SHIFT-1:ALIGN_SHIFT];
  assign f_tag          = f_pc[XLEN-1:BTB_IDX+ALIGN_SHIFT];
  assign r_bidx         = r_pc[BTB_IDX+ALIGN_SHIFT-1:ALIGN_SHIFT];
  assign r_tag          = r_pc[XLEN-1:BTB_IDX+ALIGN_SHIFT];
  assign unused_pc_bits = {f_pc[1:0], r_pc[1:0]};

  assign upd = r_valid && r_is_branch;

  // History only advances at resolve, so it never needs repair after a flush.
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ghr <= '0;
        end else if (upd) begin
          ghr <= GHR_BITS'({ghr, r_taken});
        end
      end
      assign ghr_ext = PHT_IDX'(ghr);
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  assign p_index  = f_pc[PHT_IDX+ALIGN_SHIFT-1:ALIGN_SHIFT] ^ ghr_ext;
  assign btb_hit  = btb_vld[f_bidx] && (btb_tag[f_bidx] == f_tag);
  assign p_taken  = f_valid && btb_hit && pht[p_index][1];
  assign p_target = p_taken ? btb_tgt[f_bidx] : f_pc + XLEN'(4);

  assign r_mispredict = upd && ((r_taken != r_pred_taken) ||
                                (r_taken && r_pred_taken && r_target != r_pred_target));

  generate
    for (genvar i = 0; i < PHT_N; i++) begin : g_pht
      sat_counter2 u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (upd && (r_index == PHT_IDX'(i))),
        .up    (r_taken),
        .cnt   (pht[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btb_vld <= '0;
    end else if (upd && r_taken) begin
      btb_vld[r_bidx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by btb_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (rst_n && upd && r_taken) begin
      btb_tag[r_bidx] <= r_tag;
      btb_tgt[r_bidx] <= r_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else if (upd) begin
      if (branch_count != '1) begin
        branch_count <= branch_count + 32'd1;
      end
      if (r_mispredict && mispred_count != '1) begin
        mispred_count <= mispred_count + 32'd1;
      end
    end
  end

endmodule
